// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and constants for the
// four-requester round-robin arbiter.
package rr_arbiter_4_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam string MODE_RR    = "RR";
  localparam string MODE_FIXED = "FIXED";

  localparam logic [7:0] HOLD_SAT = 8'd255;

  function automatic logic [3:0] onehot4(
    input logic [1:0] idx
  );
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/arb_pick_4.sv
// Combinational winner select: rotating
// priority from ptr, or fixed req[3]-first.
module arb_pick_4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       fixed,
  output logic [1:0] win_idx,
  output logic       win_valid
);

  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic [1:0] w_hi;

  // rotate so that bit 0 is req[ptr]
  always_comb begin
    w_rot = req;
    unique case (ptr)
      2'd0: w_rot = req;
      2'd1: w_rot = {req[0], req[3:1]};
      2'd2: w_rot = {req[1:0], req[3:2]};
      2'd3: w_rot = {req[2:0], req[3]};
      default: w_rot = req;
    endcase
  end

  // lowest set bit of rotated vector
  always_comb begin
    w_off = 2'd0;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    else if (w_rot[3]) w_off = 2'd3;
  end

  // highest set bit for fixed priority
  always_comb begin
    w_hi = 2'd0;
    if (req[3])      w_hi = 2'd3;
    else if (req[2]) w_hi = 2'd2;
    else if (req[1]) w_hi = 2'd1;
    else             w_hi = 2'd0;
  end

  assign win_idx   = fixed ? w_hi
                           : w_off + ptr;
  assign win_valid = |req;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester arbiter: one owner per
// tenure, released on done, drop or limit.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter string       MODE     = "RR",
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  localparam bit IS_FIXED =
    (MODE == MODE_FIXED);
  localparam bit HOLD_EN =
    (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST =
    HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

  arb_state_e r_state;
  arb_state_e w_state;
  logic [3:0] r_grant;
  logic [3:0] w_grant;
  logic [1:0] r_idx;
  logic [1:0] w_idx;
  logic       r_valid;
  logic       w_valid;
  logic       r_timeout;
  logic       w_timeout;
  logic [7:0] r_hold;
  logic [7:0] w_hold;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr;

  logic [1:0] w_win_idx;
  logic       w_win_valid;
  logic       w_rel_drop;
  logic       w_rel_lim;
  logic       w_rel;

  arb_pick_4 u_pick (
    .req       (req),
    .ptr       (r_ptr),
    .fixed     (IS_FIXED),
    .win_idx   (w_win_idx),
    .win_valid (w_win_valid)
  );

  assign w_rel_drop = ~req[r_idx];
  assign w_rel_lim  = HOLD_EN &&
                      (r_hold == HOLD_LAST);
  assign w_rel      = done | w_rel_drop |
                      w_rel_lim;

  // next state, tenure tracking, outputs
  always_comb begin
    w_state   = r_state;
    w_grant   = r_grant;
    w_idx     = r_idx;
    w_valid   = r_valid;
    w_timeout = 1'b0;
    w_hold    = r_hold;
    w_ptr     = r_ptr;
    unique case (r_state)
      ST_IDLE: begin
        if (w_win_valid) begin
          w_state = ST_BUSY;
          w_grant = onehot4(w_win_idx);
          w_idx   = w_win_idx;
          w_valid = 1'b1;
          w_hold  = 8'd0;
        end
      end
      ST_BUSY: begin
        if (w_rel) begin
          w_state   = ST_IDLE;
          w_grant   = 4'b0000;
          w_idx     = 2'd0;
          w_valid   = 1'b0;
          w_hold    = 8'd0;
          w_timeout = w_rel_lim & ~done &
                      ~w_rel_drop;
          if (!IS_FIXED)
            w_ptr = r_idx + 2'd1;
        end else if (r_hold != HOLD_SAT) begin
          w_hold = r_hold + 8'd1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // registered state with sync reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= 4'b0000;
      r_idx     <= 2'd0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_hold    <= 8'd0;
      r_ptr     <= 2'd0;
    end else begin
      r_state   <= w_state;
      r_grant   <= w_grant;
      r_idx     <= w_idx;
      r_valid   <= w_valid;
      r_timeout <= w_timeout;
      r_hold    <= w_hold;
      r_ptr     <= w_ptr;
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_idx;
  assign grant_valid = r_valid;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench: RR instance with hold limit 4,
// FIXED instance with default hold limit.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_rr;
  logic [3:0] req_fx;
  logic       done_rr;
  logic       done_fx;
  logic [3:0] g_rr;
  logic [3:0] g_fx;
  logic [1:0] i_rr;
  logic [1:0] i_fx;
  logic       v_rr;
  logic       v_fx;
  logic       t_rr;
  logic       t_fx;

  int checks;
  int failures;

  rr_arbiter_4 #(
    .MODE     ("RR"),
    .MAX_HOLD (4)
  ) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req_rr),
    .done        (done_rr),
    .grant       (g_rr),
    .grant_idx   (i_rr),
    .grant_valid (v_rr),
    .timeout     (t_rr)
  );

  rr_arbiter_4 #(
    .MODE     ("FIXED"),
    .MAX_HOLD (16)
  ) u_fx (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req_fx),
    .done        (done_fx),
    .grant       (g_fx),
    .grant_idx   (i_fx),
    .grant_valid (v_fx),
    .timeout     (t_fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      assert (!$isunknown(
        {req_rr, req_fx, done_rr, done_fx}))
      else begin
        failures++;
        $error("FAIL req_known observed=%b",
          {req_rr, req_fx, done_rr, done_fx});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_out(
    input logic       v,
    input logic [1:0] idx,
    input logic       to
  );
    logic [3:0] g;
    g = v ? (4'b0001 << idx) : 4'b0000;
    return {g, idx, v, to};
  endfunction

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b",
        tag, obs, exp);
    end
  endtask

  task automatic chk_rr(
    input string      tag,
    input logic       v,
    input logic [1:0] idx,
    input logic       to
  );
    chk(tag, {g_rr, i_rr, v_rr, t_rr},
      exp_out(v, idx, to));
  endtask

  task automatic chk_fx(
    input string      tag,
    input logic       v,
    input logic [1:0] idx,
    input logic       to
  );
    chk(tag, {g_fx, i_fx, v_fx, t_fx},
      exp_out(v, idx, to));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req_rr   = 4'b1111;
    req_fx   = 4'b0110;
    done_rr  = 1'b0;
    done_fx  = 1'b0;
    tick();
    tick();
    chk_rr("rr_reset", 1'b0, 2'd0, 1'b0);
    chk_fx("fx_reset", 1'b0, 2'd0, 1'b0);

    rst_n = 1'b1;
    tick();
    chk_rr("rr_first", 1'b1, 2'd0, 1'b0);
    chk_fx("fx_first", 1'b1, 2'd2, 1'b0);

    // FIXED owner drops req -> idle
    req_fx = 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      tick();
      done_rr = 1'b1;
      tick();
      done_rr = 1'b0;
      chk_rr($sformatf("rr_gap%0d", i),
        1'b0, 2'd0, 1'b0);
      tick();
      chk_rr($sformatf("rr_rot%0d", i),
        1'b1, 2'(i % 4), 1'b0);
    end
    chk_fx("fx_drop", 1'b0, 2'd0, 1'b0);

    // hold limit 4 with no done
    req_rr = 4'b0011;
    chk_rr("to_h0", 1'b1, 2'd0, 1'b0);
    tick();
    tick();
    tick();
    chk_rr("to_h3", 1'b1, 2'd0, 1'b0);
    tick();
    chk_rr("to_pulse", 1'b0, 2'd0, 1'b1);
    tick();
    chk_rr("to_next", 1'b1, 2'd1, 1'b0);

    // owner drops req in cycle 2
    tick();
    req_rr = 4'b0001;
    tick();
    chk_rr("drop_rel", 1'b0, 2'd0, 1'b0);
    tick();
    chk_rr("drop_next", 1'b1, 2'd0, 1'b0);

    // done coincides with the limit
    tick();
    tick();
    tick();
    chk_rr("prec_h3", 1'b1, 2'd0, 1'b0);
    done_rr = 1'b1;
    tick();
    done_rr = 1'b0;
    req_rr  = 4'b0000;
    chk_rr("prec_rel", 1'b0, 2'd0, 1'b0);

    // fixed priority
    req_fx = 4'b0110;
    tick();
    chk_fx("fx_a", 1'b1, 2'd2, 1'b0);
    chk_rr("rr_quiet", 1'b0, 2'd0, 1'b0);
    tick();
    done_fx = 1'b1;
    tick();
    done_fx = 1'b0;
    chk_fx("fx_done", 1'b0, 2'd0, 1'b0);
    tick();
    chk_fx("fx_again", 1'b1, 2'd2, 1'b0);
    req_fx = 4'b0011;
    tick();
    chk_fx("fx_rel2", 1'b0, 2'd0, 1'b0);
    tick();
    chk_fx("fx_b", 1'b1, 2'd1, 1'b0);
    req_fx = 4'b1001;
    tick();
    chk_fx("fx_rel3", 1'b0, 2'd0, 1'b0);
    tick();
    chk_fx("fx_c", 1'b1, 2'd3, 1'b0);

    // reset mid-tenure clears rr_ptr
    req_rr = 4'b0100;
    tick();
    chk_rr("mid_grant", 1'b1, 2'd2, 1'b0);
    rst_n  = 1'b0;
    req_rr = 4'b1111;
    tick();
    chk_rr("mid_rst_rr", 1'b0, 2'd0, 1'b0);
    chk_fx("mid_rst_fx", 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_rr("post_rst_rr", 1'b1, 2'd0, 1'b0);
    chk_fx("post_rst_fx", 1'b1, 2'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
